ballot_sender: RTL and testbench

Voter-side driver for the voting machine's keypad interface. It accepts complete 4-digit BCD registration numbers from a host through a ready/valid handshake and buffers them in a small FIFO. It replays each number onto the machine's `digit`/`valid` inputs as four digit strobes followed by a confirm strobe. On request, it closes the election by raising `finish` once all queued ballots have been sent.

---
 rtl/ballot_sender.sv | 211 +++++++++++++++++++++
 tb/tb_ballot_sender.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_sender.sv
// rtl/ballot_sender.sv - buffers 4-digit ballots and replays them as keypad digit/valid strobes
module ballot_sender #(
    parameter int FIFO_DEPTH   = 4,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] ballot_in,
    input  logic        ballot_valid,
    output logic        ballot_ready,
    input  logic        close_req,
    output logic [3:0]  digit,
    output logic        valid,
    output logic        finish,
    output logic        busy,
    output logic [7:0]  sent_count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_CGAP   = 3'd3;
    localparam logic [2:0] S_CPULSE = 3'd4;
    localparam logic [2:0] S_TAIL   = 3'd5;

    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] CNT_ONE    = 16'd1;
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0] OCC_ONE    = 1;
    localparam logic [PW:0] DEPTH_V    = FIFO_DEPTH[PW:0];

    logic [15:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   occ_q, occ_d;
    logic          full, empty, push, pop;
    logic [15:0]   head;

    logic [2:0]    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shift_q, shift_d;
    logic [3:0]    digit_q, digit_d;
    logic          valid_q, valid_d;
    logic [7:0]    sent_q, sent_d;
    logic          close_q, close_d;
    logic          finish_q, finish_d;

    assign full         = (occ_q == DEPTH_V);
    assign empty        = (occ_q == '0);
    assign head         = fifo_mem_q[rd_ptr_q];
    assign ballot_ready = !full && !close_q && !finish_q;
    assign push         = ballot_valid && ballot_ready;

    assign digit      = digit_q;
    assign valid      = valid_q;
    assign finish     = finish_q;
    assign sent_count = sent_q;
    assign busy       = (state_q != S_IDLE) || !empty;

    // Ballot storage; emptiness is tracked by the pointers, so the array needs no reset
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= ballot_in;
        end
    end

    // FIFO pointer and occupancy bookkeeping for push, pop, or both on one edge
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Strobe sequencer: four digit strobes then a confirm strobe, each framed by low gaps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        digit_d = digit_q;
        valid_d = valid_q;
        sent_d  = sent_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    digit_d = head[15:12];
                    shift_d = {head[11:0], 4'h0};
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        digit_d = shift_q[15:12];
                        shift_d = {shift_q[11:0], 4'h0};
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_CGAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_CGAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = S_CPULSE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_CPULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    state_d = S_TAIL;
                    if (sent_q != 8'hFF) begin
                        sent_d = sent_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_TAIL: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Close request is remembered; finish fires once the queue has fully drained
    always_comb begin
        close_d  = close_q | close_req;
        finish_d = finish_q | (close_q && (state_q == S_IDLE) && empty);
    end

    // State registers, cleared immediately by reset even in the middle of a strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            digit_q  <= '0;
            valid_q  <= 1'b0;
            sent_q   <= '0;
            close_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            sent_q   <= sent_d;
            close_q  <= close_d;
            finish_q <= finish_d;
        end
    end

endmodule

// File: tb/tb_ballot_sender.sv
// tb/tb_ballot_sender.sv - self-checking bench for ballot_sender
module tb_ballot_sender;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [15:0] bin_a, bin_b;
    logic        bval_a, bval_b, close_a, close_b;
    logic        ready_a, ready_b, valid_a, valid_b, finish_a, finish_b, busy_a, busy_b;
    logic [3:0]  digit_a, digit_b;
    logic [7:0]  sent_a, sent_b;

    ballot_sender dut (
        .clock(clock), .reset_n(reset_n), .ballot_in(bin_a), .ballot_valid(bval_a),
        .ballot_ready(ready_a), .close_req(close_a), .digit(digit_a), .valid(valid_a),
        .finish(finish_a), .busy(busy_a), .sent_count(sent_a)
    );

    ballot_sender #(.FIFO_DEPTH(4), .PULSE_CYCLES(3), .GAP_CYCLES(2)) dut_p (
        .clock(clock), .reset_n(reset_n), .ballot_in(bin_b), .ballot_valid(bval_b),
        .ballot_ready(ready_b), .close_req(close_b), .digit(digit_b), .valid(valid_b),
        .finish(finish_b), .busy(busy_b), .sent_count(sent_b)
    );

    typedef struct {
        logic [15:0] ballot;
        logic [3:0]  d0, d1, d2, d3;
    } vec_t;

    int cyc = 0;
    always @(posedge clock) cyc++;

    bit          rec_en = 1'b1;
    bit          sel_p  = 1'b0;
    bit          tr_v[$];
    logic [3:0]  tr_d[$];
    logic [15:0] exp_q[$];
    logic [15:0] dec_q[$];
    int          rise_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    always @(negedge clock) begin
        if (reset_n && rec_en) begin
            tr_v.push_back(sel_p ? valid_b : valid_a);
            tr_d.push_back(sel_p ? digit_b : digit_a);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bval_a = 1'b0; bval_b = 1'b0; close_a = 1'b0; close_b = 1'b0;
        bin_a = '0; bin_b = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        tr_v.delete(); tr_d.delete(); exp_q.delete();
    endtask

    task automatic push(input logic [15:0] b, output int edge_no);
        int w;
        w = 0;
        edge_no = -1;
        if (sel_p) begin bin_b = b; bval_b = 1'b1; end
        else begin bin_a = b; bval_a = 1'b1; end
        while (w < 400) begin
            @(negedge clock);
            if ((sel_p ? ready_b : ready_a) == 1'b1) begin
                @(posedge clock);
                #1;
                edge_no = cyc;
                break;
            end
            w++;
        end
        bval_a = 1'b0; bval_b = 1'b0;
        if (edge_no < 0) fail_now("push");
        else exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clock);
        while ((sel_p ? busy_b : busy_a) && w < 5000) begin
            @(negedge clock);
            w++;
        end
        if (w >= 5000) fail_now("wait_idle");
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    // Decode the recorded valid/digit waveform into ballots and count shape violations
    task automatic analyze(input int p, input int g, output int err);
        int low, plen;
        logic [3:0] d;
        logic [3:0] digs[$];
        dec_q.delete(); rise_q.delete();
        err = 0; low = 0; plen = 0; d = '0;
        for (int i = 0; i < tr_v.size(); i++) begin
            if (tr_v[i]) begin
                if (i == 0 || !tr_v[i-1]) begin
                    if (low < g) err++;
                    plen = 0;
                    d = tr_d[i];
                    if (digs.size() % 5 == 0) rise_q.push_back(i);
                end
                plen++;
                if (tr_d[i] !== d) err++;
            end else begin
                if (i > 0 && tr_v[i-1]) begin
                    if (plen != p) err++;
                    digs.push_back(d);
                    low = 0;
                end
                low++;
            end
        end
        if (tr_v.size() > 0 && tr_v[tr_v.size()-1]) err++;
        if (digs.size() % 5 != 0) err++;
        for (int k = 0; k + 5 <= digs.size(); k += 5) begin
            if (digs[k+4] !== digs[k+3]) err++;
            dec_q.push_back({digs[k], digs[k+1], digs[k+2], digs[k+3]});
        end
    endtask

    task automatic compare_list(input string tag);
        chk({tag, "_n_ballots"}, dec_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++)
            chk($sformatf("%s_ballot%0d", tag, i), int'(dec_q[i]), int'(exp_q[i]));
    endtask

    initial begin
        vec_t tbl[5];
        int   e, err, fv, brun, r, pv, hold_ok, highs;
        int   e0;
        int   rel[6];
        logic [15:0] bp[6];
        int   exp_rel[6];

        tbl[0] = '{16'h3031, 4'h3, 4'h0, 4'h3, 4'h1};
        tbl[1] = '{16'h2670, 4'h2, 4'h6, 4'h7, 4'h0};
        tbl[2] = '{16'h9A05, 4'h9, 4'hA, 4'h0, 4'h5};
        tbl[3] = '{16'h0000, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[4] = '{16'hFFFF, 4'hF, 4'hF, 4'hF, 4'hF};
        bp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        exp_rel = '{0, 1, 2, 3, 4, 14};

        // Reset values
        do_reset();
        chk("rst_digit", digit_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_finish", finish_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_sent", sent_a, 0);
        chk("rst_ready", ready_a, 1);

        // Table-driven single ballots
        for (int i = 0; i < 5; i++) begin
            tr_v.delete(); tr_d.delete(); exp_q.delete();
            push(tbl[i].ballot, e);
            if (i == 0) begin
                fv = -1; brun = 0;
                for (int k = 0; k < 30; k++) begin
                    @(negedge clock);
                    if (k == 1) chk("latency_digit", digit_a, tbl[0].d0);
                    if (valid_a && fv < 0) fv = k;
                    if (busy_a && brun == k) brun++;
                end
                chk("latency_valid", fv, 2);
                chk("busy_run", brun, 12);
            end
            wait_idle();
            analyze(1, 1, err);
            chk("tbl_shape", err, 0);
            chk("tbl_count", dec_q.size(), 1);
            if (dec_q.size() > 0)
                chk($sformatf("tbl_ballot%0d", i), int'(dec_q[0]),
                    int'({tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3}));
            chk("tbl_sent", sent_a, i + 1);
        end

        // Back-pressure with six ballots offered back to back
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push(bp[i], e);
            if (i == 0) e0 = e;
            rel[i] = e - e0;
            if (i == 4) chk("bp_ready_full", ready_a, 0);
        end
        for (int i = 0; i < 6; i++) chk($sformatf("bp_edge%0d", i), rel[i], exp_rel[i]);
        wait_idle();
        analyze(1, 1, err);
        chk("bp_shape", err, 0);
        compare_list("bp");
        if (rise_q.size() >= 2) chk("bp_period", rise_q[1] - rise_q[0], 12);
        chk("bp_sent", sent_a, 6);

        // Close with two ballots queued
        do_reset();
        push(16'h3009, e);
        push(16'h2670, e);
        r = 0;
        while (!valid_a && r < 100) begin
            @(negedge clock);
            r++;
        end
        if (r >= 100) fail_now("close_wait_valid");
        close_a = 1'b1;
        @(posedge clock);
        #1;
        close_a = 1'b0;
        @(negedge clock);
        chk("close_ready", ready_a, 0);
        r = 0;
        while (busy_a && r < 300) begin
            @(negedge clock);
            r++;
        end
        if (r >= 300) fail_now("close_drain");
        chk("finish_at_idle", finish_a, 0);
        @(negedge clock);
        chk("finish_rise", finish_a, 1);
        bin_a = 16'h1111;
        bval_a = 1'b1;
        hold_ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (finish_a && !ready_a) hold_ok++;
        end
        bval_a = 1'b0;
        chk("finish_hold", hold_ok, 10);
        analyze(1, 1, err);
        chk("close_shape", err, 0);
        compare_list("close");
        chk("close_sent", sent_a, 2);

        // Reset in the middle of the second digit strobe
        do_reset();
        push(16'h1234, e);
        push(16'h5678, e);
        push(16'h9ABC, e);
        r = 0; pv = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (valid_a && !pv) r++;
            pv = valid_a;
            if (r == 2) break;
        end
        if (r < 2) fail_now("midrst_wait");
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", valid_a, 0);
        chk("midrst_digit", digit_a, 0);
        chk("midrst_sent", sent_a, 0);
        chk("midrst_busy", busy_a, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_ready", ready_a, 1);
        highs = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (valid_a) highs++;
        end
        chk("midrst_quiet", highs, 0);

        // Stretched strobes on the second instance
        sel_p = 1'b1;
        do_reset();
        push(16'h2668, e);
        push(16'h1357, e);
        wait_idle();
        analyze(3, 2, err);
        chk("param_shape", err, 0);
        compare_list("param");
        if (rise_q.size() >= 2) chk("param_period", rise_q[1] - rise_q[0], 28);
        chk("param_sent", sent_b, 2);
        sel_p = 1'b0;

        // Randomized traffic against the waveform-decoding model
        do_reset();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 14)) begin
                @(posedge clock);
                #1;
            end
            push(16'($urandom), e);
        end
        wait_idle();
        analyze(1, 1, err);
        chk("rand_shape", err, 0);
        compare_list("rand");
        chk("rand_sent", sent_a, 20);

        // Saturation of the sent counter
        rec_en = 1'b0;
        do_reset();
        for (int i = 0; i < 255; i++) push(16'($urandom), e);
        wait_idle();
        chk("sat_255", sent_a, 255);
        push(16'h1234, e);
        push(16'h4321, e);
        wait_idle();
        chk("sat_hold", sent_a, 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
